// File: rtl/wb_command_master_if.sv
`default_nettype none
// ============================================================================
// Module      : wb_command_master_if
// Description : Command/response handshake and Wishbone master bus bundle.
//               The master modport is the command master's view; the slave
//               modport is the environment's view (command source + bus slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface wb_command_master_if #(
  parameter int WB_DWIDTH = 128,
  parameter int WB_SWIDTH = 16
);
  // Command side
  logic                 i_cmd_valid;
  logic                 o_cmd_ready;
  logic                 i_cmd_we;
  logic [31:0]          i_cmd_adr;
  logic [31:0]          i_cmd_wdata;
  // Response side
  logic                 o_rsp_valid;
  logic [31:0]          o_rsp_rdata;
  logic                 o_rsp_err;
  // Wishbone side
  logic [31:0]          o_wb_adr;
  logic [WB_SWIDTH-1:0] o_wb_sel;
  logic                 o_wb_we;
  logic [WB_DWIDTH-1:0] o_wb_dat;
  logic [WB_DWIDTH-1:0] i_wb_dat;
  logic                 o_wb_cyc;
  logic                 o_wb_stb;
  logic                 i_wb_ack;
  logic                 i_wb_err;

  modport master (
    input  i_cmd_valid, i_cmd_we, i_cmd_adr, i_cmd_wdata,
    output o_cmd_ready,
    output o_rsp_valid, o_rsp_rdata, o_rsp_err,
    output o_wb_adr, o_wb_sel, o_wb_we, o_wb_dat, o_wb_cyc, o_wb_stb,
    input  i_wb_dat, i_wb_ack, i_wb_err
  );

  modport slave (
    output i_cmd_valid, i_cmd_we, i_cmd_adr, i_cmd_wdata,
    input  o_cmd_ready,
    input  o_rsp_valid, o_rsp_rdata, o_rsp_err,
    input  o_wb_adr, o_wb_sel, o_wb_we, o_wb_dat, o_wb_cyc, o_wb_stb,
    output i_wb_dat, i_wb_ack, i_wb_err
  );
endinterface
`default_nettype wire

// File: rtl/wb_command_master.sv
`default_nettype none
// ============================================================================
// Module      : wb_command_master
// Description : Single-outstanding 32-bit command to Wishbone classic master.
//               Issues one registered bus cycle per command, waits for ack,
//               err or a timeout, and returns a one-cycle completion pulse.
//               Supports a 128-bit bus (lane steered by adr[3:2]) or 32-bit.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_command_master #(
  parameter int WB_DWIDTH      = 128,
  parameter int WB_SWIDTH      = 16,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                clk,
  input  logic                reset,
  wb_command_master_if.master bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUS  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  // Counter value seen on the last permitted bus cycle.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [1:0]           state_q, state_d;
  logic                 cyc_q;
  logic                 we_q;
  logic [31:0]          adr_q;
  logic [WB_SWIDTH-1:0] sel_q;
  logic [WB_DWIDTH-1:0] dat_q;
  logic [7:0]           cnt_q;
  logic                 err_q;
  logic [31:0]          rdata_q;

  logic                 w_timeout;
  logic [WB_SWIDTH-1:0] w_sel;
  logic [WB_DWIDTH-1:0] w_dat;
  logic [31:0]          w_lane;

  generate
    if (WB_DWIDTH == 128) begin : g_wide
      // Replicate the word on every lane; select the lane with adr[3:2].
      assign w_sel  = WB_SWIDTH'(16'h000F << {bus.i_cmd_adr[3:2], 2'b00});
      assign w_dat  = WB_DWIDTH'({4{bus.i_cmd_wdata}});
      assign w_lane = bus.i_wb_dat[{adr_q[3:2], 5'b00000} +: 32];
    end else begin : g_narrow
      assign w_sel  = '1;
      assign w_dat  = WB_DWIDTH'(bus.i_cmd_wdata);
      assign w_lane = bus.i_wb_dat[31:0];
    end
  endgenerate

  assign w_timeout = (cnt_q == TO_LAST);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state: ack/err/timeout all end the bus phase; RESP lasts one cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.i_cmd_valid) state_d = S_BUS;
      S_BUS:   if (bus.i_wb_err || bus.i_wb_ack || w_timeout) state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Handshake outputs decoded from the state.
  always_comb begin
    bus.o_cmd_ready = (state_q == S_IDLE);
    bus.o_rsp_valid = (state_q == S_RESP);
  end

  // Command capture, registered bus drive, timeout count and response capture.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cyc_q   <= 1'b0;
      we_q    <= 1'b0;
      adr_q   <= '0;
      sel_q   <= '0;
      dat_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      cyc_q <= (state_d == S_BUS);
      if (state_q == S_IDLE && bus.i_cmd_valid) begin
        we_q  <= bus.i_cmd_we;
        adr_q <= bus.i_cmd_adr;
        sel_q <= w_sel;
        dat_q <= w_dat;
        cnt_q <= '0;
      end else if (state_q == S_BUS) begin
        cnt_q <= cnt_q + 8'd1;
        // err beats ack; either beats a coincident timeout.
        if (bus.i_wb_err) begin
          err_q   <= 1'b1;
          rdata_q <= '0;
        end else if (bus.i_wb_ack) begin
          err_q   <= 1'b0;
          rdata_q <= we_q ? 32'd0 : w_lane;
        end else if (w_timeout) begin
          err_q   <= 1'b1;
          rdata_q <= '0;
        end
      end
    end
  end

  assign bus.o_wb_cyc    = cyc_q;
  assign bus.o_wb_stb    = cyc_q;
  assign bus.o_wb_we     = we_q;
  assign bus.o_wb_adr    = adr_q;
  assign bus.o_wb_sel    = sel_q;
  assign bus.o_wb_dat    = dat_q;
  assign bus.o_rsp_err   = err_q;
  assign bus.o_rsp_rdata = rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_command_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_command_master
// Description : Scoreboard bench for wb_command_master (128-bit bus,
//               TIMEOUT_CYCLES=4). Expected responses are queued at command
//               capture and popped by an independent monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_command_master;

  localparam int DW = 128;
  localparam int SW = 16;
  localparam int TO = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  wb_command_master_if #(.WB_DWIDTH(DW), .WB_SWIDTH(SW)) bus ();

  wb_command_master #(.WB_DWIDTH(DW), .WB_SWIDTH(SW), .TIMEOUT_CYCLES(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic        err;
    logic [31:0] rdata;
  } rsp_t;

  rsp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // Bus-slave configuration for the single outstanding command.
  logic        cur_we;
  logic [31:0] cur_adr;
  logic [31:0] cur_wdata;
  int          cur_d;      // stb cycle on which the slave responds
  int          cur_kind;   // 0 ack, 1 err, 2 ack+err
  bit          cur_active = 1'b0;
  int          stb_cnt    = 0;
  bit          noise      = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference model: byte selects cover the 4 bytes of the addressed word.
  function automatic logic [15:0] ref_sel(input logic [31:0] adr);
    logic [15:0] s;
    int w;
    s = '0;
    w = int'((adr / 4) % 4);
    for (int i = 0; i < 16; i++) s[i] = ((i / 4) == w);
    return s;
  endfunction

  function automatic logic [127:0] ref_dat(input logic [31:0] wd);
    logic [127:0] d;
    for (int k = 0; k < 4; k++) d[32*k +: 32] = wd;
    return d;
  endfunction

  function automatic logic [31:0] ref_lane(input logic [127:0] rb, input logic [31:0] adr);
    logic [127:0] sh;
    sh = rb >> (32 * ((adr / 4) % 4));
    return sh[31:0];
  endfunction

  // Called on the negedge before the capturing posedge.
  task automatic arm(input logic we, input logic [31:0] adr, input logic [31:0] wd,
                     input int d, input int kind, input logic [127:0] rb);
    rsp_t e;
    cur_we = we; cur_adr = adr; cur_wdata = wd; cur_d = d; cur_kind = kind;
    stb_cnt = 0; cur_active = 1'b1;
    bus.i_wb_dat = rb;
    if (d <= TO) begin
      e.err   = (kind != 0);
      e.rdata = (!we && kind == 0) ? ref_lane(rb, adr) : 32'd0;
    end else begin
      e.err   = 1'b1;
      e.rdata = 32'd0;
    end
    exp_q.push_back(e);
  endtask

  task automatic issue(input logic we, input logic [31:0] adr, input logic [31:0] wd,
                       input int d, input int kind, input logic [127:0] rb);
    int n;
    n = 0;
    bus.i_cmd_valid = 1'b1; bus.i_cmd_we = we; bus.i_cmd_adr = adr; bus.i_cmd_wdata = wd;
    while (!bus.o_cmd_ready && n < 50) begin @(negedge clk); n++; end
    if (!bus.o_cmd_ready) begin
      check("cmd_accept_bound", 128'(bus.o_cmd_ready), 128'd1);
      bus.i_cmd_valid = 1'b0;
    end else begin
      arm(we, adr, wd, d, kind, rb);
      @(negedge clk);
      bus.i_cmd_valid = 1'b0;
      bus.i_cmd_adr   = $urandom;
      bus.i_cmd_wdata = $urandom;
    end
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || cur_active) && n < 60) begin @(negedge clk); n++; end
    if (n >= 60) begin
      total++; bad++;
      $display("FAIL done_bound actual=pending required=complete");
      exp_q.delete();
      cur_active = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"},     128'(bus.o_cmd_ready), 128'd1);
    check({tag, "_rsp_valid"}, 128'(bus.o_rsp_valid), 128'd0);
    check({tag, "_rsp_err"},   128'(bus.o_rsp_err),   128'd0);
    check({tag, "_rsp_rdata"}, 128'(bus.o_rsp_rdata), 128'd0);
    check({tag, "_cyc"},       128'(bus.o_wb_cyc),    128'd0);
    check({tag, "_stb"},       128'(bus.o_wb_stb),    128'd0);
    check({tag, "_we"},        128'(bus.o_wb_we),     128'd0);
    check({tag, "_adr"},       128'(bus.o_wb_adr),    128'd0);
    check({tag, "_sel"},       128'(bus.o_wb_sel),    128'd0);
    check({tag, "_dat"},       bus.o_wb_dat,          128'd0);
  endtask

  // Wishbone slave: checks bus fields on every stb cycle and answers on cycle cur_d.
  initial begin
    bit hit;
    bus.i_wb_ack = 1'b0;
    bus.i_wb_err = 1'b0;
    forever begin
      @(negedge clk);
      if (cur_active && bus.o_wb_stb) begin
        stb_cnt++;
        check("wb_cyc", 128'(bus.o_wb_cyc), 128'd1);
        check("wb_adr", 128'(bus.o_wb_adr), 128'(cur_adr));
        check("wb_we",  128'(bus.o_wb_we),  128'(cur_we));
        check("wb_sel", 128'(bus.o_wb_sel), 128'(ref_sel(cur_adr)));
        check("wb_dat", bus.o_wb_dat,       ref_dat(cur_wdata));
        hit = (stb_cnt == cur_d);
        bus.i_wb_ack = hit && (cur_kind != 1);
        bus.i_wb_err = hit && (cur_kind != 0);
      end else begin
        if (cur_active && !bus.o_wb_cyc && stb_cnt > 0) begin
          check("stb_cycles", 128'(stb_cnt), 128'((cur_d <= TO) ? cur_d : TO));
          cur_active = 1'b0;
        end
        bus.i_wb_ack = noise && ($urandom_range(0, 1) == 1);
        bus.i_wb_err = noise && ($urandom_range(0, 3) == 0);
      end
    end
  end

  // Response monitor: every pulse must match the oldest queued expectation.
  initial begin
    rsp_t e;
    forever begin
      @(negedge clk);
      if (bus.o_rsp_valid) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL rsp_unexpected actual=rsp_valid required=no_response");
        end else begin
          e = exp_q.pop_front();
          check("rsp_err",   128'(bus.o_rsp_err),   128'(e.err));
          check("rsp_rdata", 128'(bus.o_rsp_rdata), 128'(e.rdata));
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n;
    bit  prev_rsp;
    logic [127:0] rb;
    reset = 1'b0;
    bus.i_cmd_valid = 1'b0; bus.i_cmd_we = 1'b0;
    bus.i_cmd_adr = '0; bus.i_cmd_wdata = '0; bus.i_wb_dat = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    reset = 1'b1;
    @(negedge clk);

    // 128-bit write, ack on first stb cycle.
    issue(1'b1, 32'h1400_0008, 32'h0000_0020, 1, 0, {4{32'hDEAD_BEEF}});
    wait_done();

    // 128-bit read of lane 1, ack on second stb cycle.
    rb = {32'hAAAA_0003, 32'hAAAA_0002, 32'h2233_4455, 32'hAAAA_0000};
    issue(1'b0, 32'h1400_0004, 32'h0, 2, 0, rb);
    wait_done();

    // err and ack together: err wins.
    issue(1'b0, 32'h1400_000C, 32'h0, 1, 2, {4{32'h1234_5678}});
    wait_done();

    // No response: timeout after TO stb cycles.
    issue(1'b0, 32'h0000_0010, 32'h0, 100, 0, {4{32'h5555_AAAA}});
    wait_done();

    // Ack on the same edge as the timeout: ack wins.
    issue(1'b0, 32'h0000_0018, 32'h0, TO, 0, {32'h4, 32'h3, 32'h2, 32'h1});
    wait_done();

    // Reset in the middle of a bus cycle.
    issue(1'b1, 32'h2000_0004, 32'hCAFE_F00D, 100, 0, '0);
    @(negedge clk);
    cur_active = 1'b0;
    exp_q.delete();
    reset = 1'b0;
    #1;
    check_reset_outputs("midrst");
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    issue(1'b0, 32'h2000_0008, 32'h0, 1, 0, {32'h0, 32'h7777_8888, 32'h0, 32'h0});
    wait_done();

    // Back-to-back with valid held high.
    bus.i_cmd_valid = 1'b1; bus.i_cmd_we = 1'b1;
    bus.i_cmd_adr = 32'h3000_0000; bus.i_cmd_wdata = 32'h0BAD_CAFE;
    n = 0;
    while (!bus.o_cmd_ready && n < 50) begin @(negedge clk); n++; end
    arm(1'b1, 32'h3000_0000, 32'h0BAD_CAFE, 1, 0, '0);
    @(negedge clk);
    bus.i_cmd_we = 1'b0; bus.i_cmd_adr = 32'h3000_000C; bus.i_cmd_wdata = 32'h0;
    rb = {32'h9999_0000, 32'h1, 32'h2, 32'h3};
    prev_rsp = 1'b0;
    n = 0;
    while (!bus.o_cmd_ready && n < 50) begin
      prev_rsp = bus.o_rsp_valid;
      @(negedge clk);
      n++;
    end
    check("b2b_capture_after_rsp", 128'(prev_rsp && bus.o_cmd_ready), 128'd1);
    arm(1'b0, 32'h3000_000C, 32'h0, 2, 0, rb);
    @(negedge clk);
    bus.i_cmd_valid = 1'b0;
    wait_done();

    // Randomized commands with stray ack/err outside the bus phase.
    noise = 1'b1;
    for (int t = 0; t < 40; t++) begin
      issue(1'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFFC, $urandom,
            int'($urandom_range(1, 6)), int'($urandom_range(0, 2)),
            {$urandom, $urandom, $urandom, $urandom});
      wait_done();
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    noise = 1'b0;
    repeat (4) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
